// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: resolves load-use stalls, taken-branch flushes
// and data-memory freezes, and keeps saturating stall/flush performance counters.
module hazard_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_branch_taken,
  input  logic             i_mem_busy,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_if_id_flush,
  output logic             o_id_ex_en,
  output logic             o_id_ex_bubble,
  output logic             o_ex_mem_en,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_count
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic load_use_act;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 1'b1;
    end
  endfunction

  assign rs1_hit  = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
  assign rs2_hit  = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);
  assign load_use = i_ex_mem_read && (i_ex_rd != 5'd0) && (rs1_hit || rs2_hit);

  // Only one bubble per load: a dependency seen again in STALL is already covered.
  assign load_use_act = load_use && (state_q != ST_STALL);

  always_comb begin
    o_pc_en        = 1'b1;
    o_if_id_en     = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_en     = 1'b1;
    o_id_ex_bubble = 1'b0;
    o_ex_mem_en    = 1'b1;
    state_d        = ST_RUN;
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;

    if (i_reset) begin
      stall_cycles_d = '0;
      flush_count_d  = '0;
    end else if (i_mem_busy) begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_id_ex_en     = 1'b0;
      o_ex_mem_en    = 1'b0;
      state_d        = ST_WAIT;
      stall_cycles_d = sat_inc(stall_cycles_q);
    end else if (i_ex_branch_taken) begin
      // Squash the two younger instructions; a held branch from WAIT lands here too.
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
      flush_count_d  = sat_inc(flush_count_q);
    end else if (load_use_act) begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_id_ex_bubble = 1'b1;
      state_d        = ST_STALL;
      stall_cycles_d = sat_inc(stall_cycles_q);
    end
  end

  always_ff @(posedge i_clk) begin
    state_q        <= state_d;
    stall_cycles_q <= stall_cycles_d;
    flush_count_q  <= flush_count_d;
  end

  assign o_state        = state_q;
  assign o_stall_cycles = stall_cycles_q;
  assign o_flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a CNT_W=16 instance plus a CNT_W=4
// instance sharing the same stimulus for counter saturation.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       uses_rs1, uses_rs2, ex_mem_read, br_taken, mem_busy;

  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en;
  logic [1:0]  state;
  logic [15:0] stall_cycles, flush_count;

  logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_bubble, s_ex_mem_en;
  logic [1:0]  s_state;
  logic [3:0]  s_stall_cycles, s_flush_count;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [5:0] EN_NORMAL = 6'b110101;
  localparam logic [5:0] EN_FREEZE = 6'b000000;
  localparam logic [5:0] EN_FLUSH  = 6'b111111;
  localparam logic [5:0] EN_STALL  = 6'b000111;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.CNT_W(16)) u_dut (
    .i_clk(clk), .i_reset(rst),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_uses_rs1(uses_rs1), .i_id_uses_rs2(uses_rs2),
    .i_ex_rd(ex_rd), .i_ex_mem_read(ex_mem_read),
    .i_ex_branch_taken(br_taken), .i_mem_busy(mem_busy),
    .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_if_id_flush(if_id_flush),
    .o_id_ex_en(id_ex_en), .o_id_ex_bubble(id_ex_bubble), .o_ex_mem_en(ex_mem_en),
    .o_state(state), .o_stall_cycles(stall_cycles), .o_flush_count(flush_count)
  );

  hazard_stall_ctrl #(.CNT_W(4)) u_sat (
    .i_clk(clk), .i_reset(rst),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_uses_rs1(uses_rs1), .i_id_uses_rs2(uses_rs2),
    .i_ex_rd(ex_rd), .i_ex_mem_read(ex_mem_read),
    .i_ex_branch_taken(br_taken), .i_mem_busy(mem_busy),
    .o_pc_en(s_pc_en), .o_if_id_en(s_if_id_en), .o_if_id_flush(s_if_id_flush),
    .o_id_ex_en(s_id_ex_en), .o_id_ex_bubble(s_id_ex_bubble), .o_ex_mem_en(s_ex_mem_en),
    .o_state(s_state), .o_stall_cycles(s_stall_cycles), .o_flush_count(s_flush_count)
  );

  function automatic logic [5:0] en_vec();
    return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_en};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    uses_rs1 = 1'b0; uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    br_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; uses_rs1 = 1'b1; id_rs1 = 5'd5;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    // Reset: combinational outputs forced to normal even with busy/branch/load-use
    mem_busy = 1'b1; br_taken = 1'b1; set_load_use();
    settle();
    check("reset_en", en_vec(), EN_NORMAL);
    tick();
    check("reset_state", state, 0);
    check("reset_stall", stall_cycles, 0);
    check("reset_flush", flush_count, 0);
    rst = 1'b0;
    clear_inputs();
    tick();

    // Load-use: one stall cycle, then normal while dependency persists
    set_load_use();
    settle();
    check("lu_en", en_vec(), EN_STALL);
    tick();
    check("lu_state", state, 1);
    check("lu_stall_cnt", stall_cycles, 1);
    settle();
    check("lu_stall_en", en_vec(), EN_NORMAL);
    tick();
    check("lu_back_run", state, 0);
    check("lu_stall_cnt2", stall_cycles, 1);

    // rd=x0 and unused rs2 never stall
    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd0; uses_rs1 = 1'b1; id_rs1 = 5'd0;
    settle();
    check("x0_en", en_vec(), EN_NORMAL);
    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; uses_rs2 = 1'b0;
    settle();
    check("nouse_en", en_vec(), EN_NORMAL);
    uses_rs2 = 1'b1;
    settle();
    check("rs2_use_en", en_vec(), EN_STALL);
    uses_rs2 = 1'b0;
    tick();
    check("nouse_state", state, 0);
    check("nouse_stall_cnt", stall_cycles, 1);

    // Branch taken
    clear_inputs();
    br_taken = 1'b1;
    settle();
    check("br_en", en_vec(), EN_FLUSH);
    tick();
    check("br_state", state, 0);
    check("br_flush_cnt", flush_count, 1);

    // Memory wait for 3 cycles during a load-use, then the stall
    clear_inputs();
    set_load_use();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("wait_en", en_vec(), EN_FREEZE);
      tick();
      check("wait_state", state, 2);
    end
    check("wait_stall_cnt", stall_cycles, 4);
    mem_busy = 1'b0;
    settle();
    check("wait_exit_en", en_vec(), EN_STALL);
    tick();
    check("wait_exit_state", state, 1);
    check("wait_exit_stall_cnt", stall_cycles, 5);
    clear_inputs();
    tick();
    check("wait_done_state", state, 0);

    // Branch + load-use: flush wins
    set_load_use();
    br_taken = 1'b1;
    settle();
    check("br_lu_en", en_vec(), EN_FLUSH);
    tick();
    check("br_lu_state", state, 0);
    check("br_lu_flush_cnt", flush_count, 2);
    check("br_lu_stall_cnt", stall_cycles, 5);

    // Busy + branch: freeze first, flush once busy drops
    clear_inputs();
    br_taken = 1'b1; mem_busy = 1'b1;
    settle();
    check("busy_br_en", en_vec(), EN_FREEZE);
    tick();
    check("busy_br_state", state, 2);
    check("busy_br_flush_cnt", flush_count, 2);
    mem_busy = 1'b0;
    settle();
    check("busy_br_exit_en", en_vec(), EN_FLUSH);
    tick();
    check("busy_br_exit_state", state, 0);
    check("busy_br_exit_flush_cnt", flush_count, 3);
    check("busy_br_stall_cnt", stall_cycles, 6);
    check("sat_cnt_pre", s_stall_cycles, 6);

    // Saturation: 14 more busy cycles -> 20 stall cycles total
    clear_inputs();
    mem_busy = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("sat_cnt", s_stall_cycles, 15);
    check("wide_cnt", stall_cycles, 20);
    check("sat_flush_cnt", s_flush_count, 3);

    // Reset mid-STALL
    clear_inputs();
    set_load_use();
    tick();
    check("pre_rst_state", state, 1);
    rst = 1'b1;
    settle();
    check("rst_stall_en", en_vec(), EN_NORMAL);
    tick();
    check("rst_stall_state", state, 0);
    check("rst_stall_cnt", stall_cycles, 0);
    check("rst_flush_cnt", flush_count, 0);
    check("rst_sat_cnt", s_stall_cycles, 0);

    // Reset mid-WAIT
    rst = 1'b0;
    clear_inputs();
    mem_busy = 1'b1;
    tick();
    check("pre_rst_wait", state, 2);
    check("pre_rst_wait_cnt", stall_cycles, 1);
    rst = 1'b1;
    tick();
    check("rst_wait_state", state, 0);
    check("rst_wait_cnt", stall_cycles, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their enables, flushes and bubble inserts. It resolves three conditions: load-use data hazards (one-cycle stall plus bubble), taken branches resolved in EX (flush of the two younger instructions), and data-memory wait states (full-pipeline freeze). Saturating performance counters record stall cycles and flush events.

## Interface
- CNT_W, 16, width of the performance counters
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_id_rs1  in  5  rs1 index of the instruction in ID
- i_id_rs2  in  5  rs2 index of the instruction in ID
- i_id_uses_rs1  in  1  ID instruction reads rs1
- i_id_uses_rs2  in  1  ID instruction reads rs2
- i_ex_rd  in  5  rd of the instruction in EX (ID/EX output)
- i_ex_mem_read  in  1  EX instruction is a load (ID/EX mem_read output)
- i_ex_branch_taken  in  1  EX branch resolved taken this cycle
- i_mem_busy  in  1  data memory not ready; MEM stage must hold
- o_pc_en  out  1  PC register load enable
- o_if_id_en  out  1  IF/ID load enable
- o_if_id_flush  out  1  IF/ID loads NOP (0x00000013) instead of fetched word
- o_id_ex_en  out  1  ID/EX load enable
- o_id_ex_bubble  out  1  ID/EX loads all-zero control fields (reg_write, mem_read, mem_write, mem_to_reg, branch, alu_op)
- o_ex_mem_en  out  1  EX/MEM load enable
- o_state  out  2  FSM state: 0 RUN, 1 STALL, 2 WAIT
- o_stall_cycles  out  CNT_W  count of cycles with o_pc_en=0
- o_flush_count  out  CNT_W  count of taken-branch flushes

## Operation
- load_use = i_ex_mem_read & (i_ex_rd != 0) & ((i_id_uses_rs1 & i_id_rs1 == i_ex_rd) | (i_id_uses_rs2 & i_id_rs2 == i_ex_rd)).
- Enable and flush outputs are combinational from state and inputs. State and counters are registered.
- Priority in every state: i_mem_busy > i_ex_branch_taken > load_use.
- Freeze (i_mem_busy=1): all four enables 0, flush 0, bubble 0. Next state WAIT.
- Flush (branch taken, not busy): pc_en=1, if_id_en=1, if_id_flush=1, id_ex_en=1, id_ex_bubble=1, ex_mem_en=1. Next state RUN. flush_count increments.
- Load-use (state RUN only, no busy, no branch): pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1, ex_mem_en=1. Next state STALL.
- Normal: all enables 1, flush 0, bubble 0. Next state RUN.
- STALL: load_use detection is suppressed, which guarantees exactly one bubble per load. Busy and branch still apply. With neither active, behaves as Normal and returns to RUN.
- WAIT: stays while i_mem_busy=1. On deassertion, evaluates the same cycle exactly as in RUN: a pending load_use or branch is acted on immediately.
- Counters increment by 1 and saturate at all-ones; they never wrap.

## Timing
- Reset (synchronous): state=RUN, o_stall_cycles=0, o_flush_count=0.
- Combinational outputs while i_reset=1: all enables 1, flush 0, bubble 0.
- Zero-cycle latency from inputs to enable/flush/bubble outputs. State and counters update on the next rising edge.
- Load-use costs exactly 1 stall cycle. A branch costs 2 squashed instructions and 0 stall cycles. A freeze lasts as long as i_mem_busy is high.
- Simultaneous busy + branch: the freeze wins. i_ex_branch_taken must be held by the frozen EX stage, so the flush occurs in the first non-busy cycle.
- Simultaneous branch + load_use: the flush wins. No stall; the load-dependent instruction is squashed.
- A reset asserted mid-STALL or mid-WAIT returns to RUN on the next edge. Counters clear.

## Test plan
- Load-use: EX=lw x5 (i_ex_mem_read=1, i_ex_rd=5), ID uses rs1=5 -> one cycle of pc_en=0, if_id_en=0, id_ex_bubble=1, state=STALL; next cycle all enables 1, state=RUN; o_stall_cycles=1.
- rd=x0 or no-use: i_ex_rd=0 with rs1=0, or i_id_uses_rs2=0 with a matching rs2 -> no stall; o_stall_cycles unchanged.
- Branch taken: i_ex_branch_taken=1 for 1 cycle -> if_id_flush=1, id_ex_bubble=1, pc_en=1; o_flush_count=1.
- Memory wait: i_mem_busy=1 for 3 cycles during a load_use condition -> 3 cycles with all enables 0 and state=WAIT, then a 1-cycle load-use stall; o_stall_cycles=4.
- Priority: branch and load_use asserted together -> flush only, no STALL. Busy and branch together -> freeze only, then flush once busy drops.
- Saturation/reset: CNT_W=4 with 20 stall cycles -> o_stall_cycles=15; asserting i_reset in STALL -> state=RUN and counters 0 next edge.
